ibex_wb_stage: RTL and testbench

In-order writeback buffer between `ibex_ex_block` and the register file. Accepts every completing instruction from EX and holds it in a small in-order queue. Loads and stores wait in the queue for their LSU response. Entries retire in program order through the register-file write port. It also flags read-after-write hazards against entries that have not yet retired.

---
 rtl/ibex_wb_stage.sv | 141 ++++++++++++++
 tb/tb_ibex_wb_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_stage.sv
// In-order writeback buffer: holds completing EX instructions, waits for LSU
// responses on loads/stores, and retires entries in program order to the register file.
module ibex_wb_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_wb_i,
    input  logic [1:0]              instr_type_wb_i,
    input  logic                    rf_we_i,
    input  logic [4:0]              rf_waddr_i,
    input  logic [31:0]             rf_wdata_i,
    output logic                    ready_o,
    input  logic                    lsu_resp_valid_i,
    input  logic [31:0]             lsu_rdata_i,
    input  logic                    lsu_err_i,
    input  logic [4:0]              rf_raddr_a_i,
    input  logic [4:0]              rf_raddr_b_i,
    output logic                    hazard_o,
    output logic                    rf_we_wb_o,
    output logic [4:0]              rf_waddr_wb_o,
    output logic [31:0]             rf_wdata_wb_o,
    output logic                    instr_done_wb_o,
    output logic                    lsu_resp_unexpected_o,
    output logic [$clog2(DEPTH):0]  outstanding_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] TYPE_EX    = 2'd0;
    localparam logic [1:0] TYPE_LOAD  = 2'd1;
    localparam logic [1:0] TYPE_STORE = 2'd2;
    localparam logic [1:0] TYPE_NONE  = 2'd3;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] we_q;
    logic [DEPTH-1:0] done_q;
    logic [1:0]       type_q  [DEPTH];
    logic [4:0]       waddr_q [DEPTH];
    logic [31:0]      data_q  [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          push;
    logic          retire;
    logic          tgt_found;
    logic [PW-1:0] tgt_idx;
    logic [PW-1:0] scan_idx;
    logic          resp_hit;
    logic          push_we;
    logic          push_done;
    logic          hazard;

    assign ready_o   = (count_q < CW'(DEPTH));
    assign push      = en_wb_i & ready_o;
    assign retire    = valid_q[head_q] & done_q[head_q];
    assign push_we   = rf_we_i & (rf_waddr_i != 5'd0)
                     & ((instr_type_wb_i == TYPE_EX) | (instr_type_wb_i == TYPE_LOAD));
    assign push_done = (instr_type_wb_i == TYPE_EX) | (instr_type_wb_i == TYPE_NONE);

    // Oldest load/store still waiting for its response, scanned from head.
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!tgt_found && valid_q[scan_idx] && !done_q[scan_idx] &&
                ((type_q[scan_idx] == TYPE_LOAD) || (type_q[scan_idx] == TYPE_STORE))) begin
                tgt_found = 1'b1;
                tgt_idx   = scan_idx;
            end
        end
    end

    assign resp_hit              = lsu_resp_valid_i & tgt_found;
    assign lsu_resp_unexpected_o = lsu_resp_valid_i & ~tgt_found;

    // Retiring entry is still included: the register file has no write-through.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && we_q[i] &&
                ((waddr_q[i] == rf_raddr_a_i) || (waddr_q[i] == rf_raddr_b_i))) begin
                hazard = 1'b1;
            end
        end
    end

    assign hazard_o        = hazard;
    assign instr_done_wb_o = retire;
    assign rf_we_wb_o      = retire & we_q[head_q];
    assign rf_waddr_wb_o   = retire ? waddr_q[head_q] : 5'd0;
    assign rf_wdata_wb_o   = retire ? data_q[head_q] : 32'd0;
    assign outstanding_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            we_q    <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]  <= TYPE_EX;
                waddr_q[i] <= 5'd0;
                data_q[i]  <= 32'd0;
            end
        end else begin
            if (resp_hit) begin
                done_q[tgt_idx] <= 1'b1;
                if (type_q[tgt_idx] == TYPE_LOAD) begin
                    data_q[tgt_idx] <= lsu_rdata_i;
                end
                if (lsu_err_i) begin
                    we_q[tgt_idx] <= 1'b0;
                end
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            // Tail slot is always free on a push, so it never collides with head or target.
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                type_q[tail_q]  <= instr_type_wb_i;
                we_q[tail_q]    <= push_we;
                waddr_q[tail_q] <= rf_waddr_i;
                data_q[tail_q]  <= rf_wdata_i;
                done_q[tail_q]  <= push_done;
                tail_q          <= tail_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(retire);
        end
    end

endmodule

// File: tb/tb_ibex_wb_stage.sv
// Directed bench for ibex_wb_stage: queue-based reference model checked every
// cycle, plus literal expectations on the retirement log.
module tb_ibex_wb_stage;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    itype;
    logic          rf_we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          ready;
    logic          resp_v;
    logic [31:0]   rdata;
    logic          err;
    logic [4:0]    ra;
    logic [4:0]    rb;
    logic          hazard;
    logic          we_wb;
    logic [4:0]    waddr_wb;
    logic [31:0]   wdata_wb;
    logic          done_wb;
    logic          unexp;
    logic [CW-1:0] outst;

    ibex_wb_stage #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .en_wb_i               (en),
        .instr_type_wb_i       (itype),
        .rf_we_i               (rf_we),
        .rf_waddr_i            (waddr),
        .rf_wdata_i            (wdata),
        .ready_o               (ready),
        .lsu_resp_valid_i      (resp_v),
        .lsu_rdata_i           (rdata),
        .lsu_err_i             (err),
        .rf_raddr_a_i          (ra),
        .rf_raddr_b_i          (rb),
        .hazard_o              (hazard),
        .rf_we_wb_o            (we_wb),
        .rf_waddr_wb_o         (waddr_wb),
        .rf_wdata_wb_o         (wdata_wb),
        .instr_done_wb_o       (done_wb),
        .lsu_resp_unexpected_o (unexp),
        .outstanding_o         (outst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        done;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    ent_t q[$];
    wr_t  log_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    bit   armed   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain queue, updated on every rising edge.
    always @(posedge clk) begin
        bit   do_pop;
        bit   do_push;
        bit   hit;
        ent_t e;
        cyc++;
        if (rst) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            do_pop  = (q.size() > 0) && q[0].done;
            do_push = en && (q.size() < DEPTH);
            if (resp_v) begin
                hit = 1'b0;
                for (int j = 0; j < q.size(); j++) begin
                    if (!hit && (q[j].kind == 2'd1 || q[j].kind == 2'd2) && !q[j].done) begin
                        hit = 1'b1;
                        q[j].done = 1'b1;
                        if (q[j].kind == 2'd1) q[j].data = rdata;
                        if (err) q[j].we = 1'b0;
                    end
                end
            end
            if (do_pop) q.delete(0);
            if (do_push) begin
                e.kind  = itype;
                e.we    = rf_we && (waddr != 5'd0) && (itype == 2'd0 || itype == 2'd1);
                e.waddr = waddr;
                e.data  = wdata;
                e.done  = (itype == 2'd0 || itype == 2'd3);
                q.push_back(e);
            end
        end
    end

    // Compare DUT against model on the falling edge; log every retirement.
    always @(negedge clk) begin
        bit e_ret;
        bit e_haz;
        bit e_pend;
        if (armed) begin
            e_ret  = (q.size() > 0) && q[0].done;
            e_haz  = 1'b0;
            e_pend = 1'b0;
            foreach (q[j]) begin
                if (q[j].we && (q[j].waddr == ra || q[j].waddr == rb)) e_haz = 1'b1;
                if ((q[j].kind == 2'd1 || q[j].kind == 2'd2) && !q[j].done) e_pend = 1'b1;
            end
            chk("ready",       32'(ready),    32'(q.size() < DEPTH));
            chk("outstanding", 32'(outst),    32'(q.size()));
            chk("hazard",      32'(hazard),   32'(e_haz));
            chk("unexpected",  32'(unexp),    32'(resp_v && !e_pend));
            chk("instr_done",  32'(done_wb),  32'(e_ret));
            chk("rf_we",       32'(we_wb),    e_ret ? 32'(q[0].we) : 32'd0);
            chk("rf_waddr",    32'(waddr_wb), e_ret ? 32'(q[0].waddr) : 32'd0);
            chk("rf_wdata",    wdata_wb,      e_ret ? q[0].data : 32'd0);
            if (done_wb) log_q.push_back('{we_wb, waddr_wb, wdata_wb, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        en     = 1'b0;
        resp_v = 1'b0;
        err    = 1'b0;
    endtask

    task automatic set_push(input logic [1:0] k, input logic w, input logic [4:0] a,
                            input logic [31:0] d);
        en    = 1'b1;
        itype = k;
        rf_we = w;
        waddr = a;
        wdata = d;
    endtask

    task automatic set_resp(input logic [31:0] d, input logic e);
        resp_v = 1'b1;
        rdata  = d;
        err    = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rc;
        rst = 1'b1; en = 1'b0; itype = 2'd0; rf_we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        resp_v = 1'b0; rdata = 32'd0; err = 1'b0; ra = 5'd0; rb = 5'd0;
        idle(2);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_outst", 32'(outst), 32'd0);
        chk("rst_done",  32'(done_wb), 32'd0);

        // Back-to-back ALU writes
        log_q.delete();
        set_push(2'd0, 1'b1, 5'd5, 32'h11); tick();
        set_push(2'd0, 1'b1, 5'd6, 32'h22);
        @(negedge clk);
        chk("b2b_outst1", 32'(outst), 32'd1);
        chk("b2b_ready",  32'(ready), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b_outst2", 32'(outst), 32'd1);
        idle(2);
        chk("b2b_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("b2b_x5",   {log_q[0].we, 26'(log_q[0].waddr)}, {1'b1, 26'd5});
            chk("b2b_d5",   log_q[0].data, 32'h11);
            chk("b2b_x6",   {log_q[1].we, 26'(log_q[1].waddr)}, {1'b1, 26'd6});
            chk("b2b_d6",   log_q[1].data, 32'h22);
            chk("b2b_gap",  32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
        end

        // Load x7 then ALU x8; full queue rejects a push; response later
        log_q.delete();
        set_push(2'd1, 1'b1, 5'd7, 32'h0); tick();
        set_push(2'd0, 1'b1, 5'd8, 32'h8); tick();
        set_push(2'd0, 1'b1, 5'd9, 32'h99); ra = 5'd7;
        @(negedge clk);
        chk("full_ready", 32'(ready), 32'd0);
        chk("haz_x7",     32'(hazard), 32'd1);
        tick();
        ra = 5'd0; set_resp(32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("haz_x0", 32'(hazard), 32'd0);
        rc = cyc;
        tick();
        idle(3);
        chk("ld_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("ld_x7",   32'(log_q[0].waddr), 32'd7);
            chk("ld_d7",   log_q[0].data, 32'hDEADBEEF);
            chk("ld_lat",  32'(log_q[0].cyc - rc), 32'd1);
            chk("ld_x8",   32'(log_q[1].waddr), 32'd8);
            chk("ld_gap",  32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
        end

        // Store then load x9
        log_q.delete();
        set_push(2'd2, 1'b1, 5'd3, 32'h55); tick();
        set_push(2'd1, 1'b1, 5'd9, 32'h0);  tick();
        set_resp(32'h0, 1'b0);    tick();
        set_resp(32'h1234, 1'b0); tick();
        idle(3);
        chk("st_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("st_we",  32'(log_q[0].we), 32'd0);
            chk("x9_we",  32'(log_q[1].we), 32'd1);
            chk("x9_adr", 32'(log_q[1].waddr), 32'd9);
            chk("x9_dat", log_q[1].data, 32'h1234);
        end

        // Load x10 with bus error
        log_q.delete();
        set_push(2'd1, 1'b1, 5'd10, 32'h0); tick();
        set_resp(32'hAAAA, 1'b1); tick();
        idle(2);
        chk("err_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("err_we", 32'(log_q[0].we), 32'd0);

        // Response with empty queue
        set_resp(32'h0, 1'b0);
        @(negedge clk);
        chk("unexp_empty", 32'(unexp), 32'd1);
        tick();

        // ALU write to x0
        log_q.delete();
        set_push(2'd0, 1'b1, 5'd0, 32'h5); tick();
        idle(2);
        chk("x0_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("x0_we", 32'(log_q[0].we), 32'd0);

        // Push, response and retire in one cycle
        log_q.delete();
        set_push(2'd1, 1'b1, 5'd12, 32'h0); tick();
        set_push(2'd0, 1'b1, 5'd13, 32'h13); set_resp(32'h12, 1'b0); tick();
        idle(3);
        chk("sim_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("sim_d12", log_q[0].data, 32'h12);
            chk("sim_d13", log_q[1].data, 32'h13);
        end

        // Reset with a pending load, then a stray response
        log_q.delete();
        set_push(2'd1, 1'b1, 5'd11, 32'h0); tick();
        rst = 1'b1; tick();
        rst = 1'b0; set_resp(32'hCAFE, 1'b0);
        @(negedge clk);
        chk("rst_unexp", 32'(unexp), 32'd1);
        tick();
        idle(2);
        chk("rst_nowrite", 32'(log_q.size()), 32'd0);
        chk("rst_outst2",  32'(outst), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
